// File: rtl/snitch_icache_l0_nb.sv
// Non-blocking L0 instruction cache: several tagged line refills in flight,
// next-line prefetch and sticky per-line refill error.
module snitch_icache_l0_nb #(
  parameter int unsigned FETCH_AW       = 32,
  parameter int unsigned FETCH_DW       = 32,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned LINE_COUNT     = 8,
  parameter int unsigned MAX_PENDING    = 2,
  parameter int unsigned PREFETCH_DEPTH = 2,
  parameter int unsigned L0_ID          = 0,
  parameter int unsigned ID_WIDTH       = $clog2(LINE_COUNT) + 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_valid_i,
  input  logic                  enable_prefetching_i,
  input  logic [FETCH_AW-1:0]   in_addr_i,
  input  logic                  in_valid_i,
  output logic [FETCH_DW-1:0]   in_data_o,
  output logic                  in_ready_o,
  output logic                  in_error_o,
  output logic [FETCH_AW-1:0]   out_req_addr_o,
  output logic [ID_WIDTH-1:0]   out_req_id_o,
  output logic                  out_req_valid_o,
  input  logic                  out_req_ready_i,
  input  logic [LINE_WIDTH-1:0] out_rsp_data_i,
  input  logic                  out_rsp_error_i,
  input  logic [ID_WIDTH-1:0]   out_rsp_id_i,
  input  logic                  out_rsp_valid_i,
  output logic                  out_rsp_ready_o,
  output logic                  evt_hit_o,
  output logic                  evt_miss_o,
  output logic                  evt_prefetch_o,
  output logic                  evt_stall_o
);

  localparam int unsigned OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned TAG_W  = FETCH_AW - OFF_W;
  localparam int unsigned IDX_W  = $clog2(LINE_COUNT);
  localparam int unsigned BYTE_W = $clog2(FETCH_DW / 8);
  localparam int unsigned WORDS  = LINE_WIDTH / FETCH_DW;
  localparam int unsigned WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W  = $clog2(LINE_COUNT + 1);
  localparam int unsigned ID_HI  = ID_WIDTH - IDX_W;

  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_PENDING = 2'd1,
    ST_VALID   = 2'd2
  } line_st_e;

  line_st_e              r_st   [LINE_COUNT];
  logic [TAG_W-1:0]      r_tag  [LINE_COUNT];
  logic [LINE_WIDTH-1:0] r_data [LINE_COUNT];
  logic [LINE_COUNT-1:0] r_err;
  logic [IDX_W-1:0]      r_ptr;
  logic                  r_req_valid;
  logic [FETCH_AW-1:0]   r_req_addr;
  logic [ID_WIDTH-1:0]   r_req_id;

  logic [TAG_W-1:0]      w_in_tag;
  logic [LINE_COUNT-1:0] w_hit_vec;
  logic [LINE_COUNT-1:0] w_present_vec;
  logic [LINE_WIDTH-1:0] w_hit_line;
  logic [WSEL_W-1:0]     w_word;
  logic [CNT_W-1:0]      w_pend_cnt;
  logic                  w_victim_found;
  logic [IDX_W-1:0]      w_victim;
  logic [IDX_W-1:0]      w_rr_idx;
  logic [TAG_W-1:0]      w_probe_tag;
  logic                  w_probe_present;
  logic                  w_pf_found;
  logic [TAG_W-1:0]      w_pf_tag;
  logic                  w_can_alloc;
  logic                  w_alloc_demand;
  logic                  w_alloc_pf;
  logic                  w_alloc;
  logic [TAG_W-1:0]      w_alloc_tag;
  logic [IDX_W-1:0]      w_rsp_slot;
  logic [ID_HI-1:0]      w_l0_id;
  logic                  w_unused_rsp_id;

  assign w_in_tag        = in_addr_i[FETCH_AW-1:OFF_W];
  assign w_word          = WSEL_W'((in_addr_i >> BYTE_W) % WORDS);
  assign w_rsp_slot      = out_rsp_id_i[IDX_W-1:0];
  assign w_l0_id         = ID_HI'(L0_ID);
  assign w_unused_rsp_id = ^out_rsp_id_i[ID_WIDTH-1:IDX_W];

  // Tag lookup, pending count, round-robin victim and prefetch probe.
  always_comb begin
    w_hit_vec       = '0;
    w_present_vec   = '0;
    w_hit_line      = '0;
    w_pend_cnt      = '0;
    w_victim_found  = 1'b0;
    w_victim        = '0;
    w_rr_idx        = '0;
    w_probe_tag     = '0;
    w_probe_present = 1'b0;
    w_pf_found      = 1'b0;
    w_pf_tag        = '0;
    for (int i = 0; i < int'(LINE_COUNT); i++) begin
      w_hit_vec[i]     = (r_st[i] == ST_VALID) && (r_tag[i] == w_in_tag);
      w_present_vec[i] = (r_st[i] != ST_INVALID) && (r_tag[i] == w_in_tag);
      w_hit_line       = w_hit_line | (w_hit_vec[i] ? r_data[i] : {LINE_WIDTH{1'b0}});
      w_pend_cnt       = w_pend_cnt + CNT_W'(r_st[i] == ST_PENDING);
    end
    for (int k = 0; k < int'(LINE_COUNT); k++) begin
      w_rr_idx = r_ptr + IDX_W'(k);
      if (!w_victim_found && (r_st[w_rr_idx] != ST_PENDING)) begin
        w_victim_found = 1'b1;
        w_victim       = w_rr_idx;
      end else begin
        w_victim_found = w_victim_found;
      end
    end
    // Probe tags wrap naturally in TAG_W-bit arithmetic.
    for (int d = 1; d <= int'(PREFETCH_DEPTH); d++) begin
      w_probe_tag     = w_in_tag + TAG_W'(d);
      w_probe_present = 1'b0;
      for (int i = 0; i < int'(LINE_COUNT); i++) begin
        w_probe_present = w_probe_present |
                          ((r_st[i] != ST_INVALID) && (r_tag[i] == w_probe_tag));
      end
      if (!w_pf_found && !w_probe_present) begin
        w_pf_found = 1'b1;
        w_pf_tag   = w_probe_tag;
      end else begin
        w_pf_found = w_pf_found;
      end
    end
  end

  assign w_can_alloc    = !r_req_valid && (w_pend_cnt < CNT_W'(MAX_PENDING)) &&
                          w_victim_found && !flush_valid_i;
  assign w_alloc_demand = in_valid_i && !(|w_present_vec) && w_can_alloc;
  assign w_alloc_pf     = in_valid_i && (|w_hit_vec) && enable_prefetching_i &&
                          w_pf_found && w_can_alloc && !w_alloc_demand;
  assign w_alloc        = w_alloc_demand || w_alloc_pf;
  assign w_alloc_tag    = w_alloc_demand ? w_in_tag : w_pf_tag;

  assign in_ready_o      = in_valid_i && (|w_hit_vec);
  assign in_error_o      = in_ready_o && (|(w_hit_vec & r_err));
  assign in_data_o       = in_ready_o ? w_hit_line[w_word*FETCH_DW +: FETCH_DW] : {FETCH_DW{1'b0}};
  assign out_req_valid_o = r_req_valid;
  assign out_req_addr_o  = r_req_addr;
  assign out_req_id_o    = r_req_id;
  assign out_rsp_ready_o = 1'b1;
  assign evt_hit_o       = in_ready_o;
  assign evt_miss_o      = w_alloc_demand;
  assign evt_prefetch_o  = w_alloc_pf;
  assign evt_stall_o     = in_valid_i && !in_ready_o;

  // Line state, refill capture, allocation and the single request register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(LINE_COUNT); i++) begin
        r_st[i]   <= ST_INVALID;
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
      r_err       <= '0;
      r_ptr       <= '0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_id    <= '0;
    end else begin
      if (r_req_valid && out_req_ready_i) begin
        r_req_valid <= 1'b0;
      end
      // Responses to slots no longer PENDING (flushed or reset) are dropped.
      if (out_rsp_valid_i && (r_st[w_rsp_slot] == ST_PENDING)) begin
        r_data[w_rsp_slot] <= out_rsp_data_i;
        r_err[w_rsp_slot]  <= out_rsp_error_i;
        r_st[w_rsp_slot]   <= ST_VALID;
      end
      if (w_alloc) begin
        r_st[w_victim]  <= ST_PENDING;
        r_tag[w_victim] <= w_alloc_tag;
        r_err[w_victim] <= 1'b0;
        r_ptr           <= w_victim + IDX_W'(1);
        r_req_valid     <= 1'b1;
        r_req_addr      <= {w_alloc_tag, {OFF_W{1'b0}}};
        r_req_id        <= {w_l0_id, w_victim};
      end
      if (flush_valid_i) begin
        for (int i = 0; i < int'(LINE_COUNT); i++) begin
          r_st[i] <= ST_INVALID;
        end
      end
    end
  end

endmodule

// File: tb/tb_snitch_icache_l0_nb.sv
// Self-checking bench for snitch_icache_l0_nb: hit vector table, request
// scoreboard, and directed refill / prefetch / flush / reset sequences.
module tb_snitch_icache_l0_nb;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         flush_valid_i;
  logic         enable_prefetching_i;
  logic [31:0]  in_addr_i;
  logic         in_valid_i;
  logic [31:0]  in_data_o;
  logic         in_ready_o;
  logic         in_error_o;
  logic [31:0]  out_req_addr_o;
  logic [5:0]   out_req_id_o;
  logic         out_req_valid_o;
  logic         out_req_ready_i;
  logic [127:0] out_rsp_data_i;
  logic         out_rsp_error_i;
  logic [5:0]   out_rsp_id_i;
  logic         out_rsp_valid_i;
  logic         out_rsp_ready_o;
  logic         evt_hit_o, evt_miss_o, evt_prefetch_o, evt_stall_o;

  always #5 clk = ~clk;

  snitch_icache_l0_nb #(
    .FETCH_AW(32), .FETCH_DW(32), .LINE_WIDTH(128), .LINE_COUNT(8),
    .MAX_PENDING(2), .PREFETCH_DEPTH(2), .L0_ID(0), .ID_WIDTH(6)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_valid_i(flush_valid_i),
    .enable_prefetching_i(enable_prefetching_i),
    .in_addr_i(in_addr_i), .in_valid_i(in_valid_i), .in_data_o(in_data_o),
    .in_ready_o(in_ready_o), .in_error_o(in_error_o),
    .out_req_addr_o(out_req_addr_o), .out_req_id_o(out_req_id_o),
    .out_req_valid_o(out_req_valid_o), .out_req_ready_i(out_req_ready_i),
    .out_rsp_data_i(out_rsp_data_i), .out_rsp_error_i(out_rsp_error_i),
    .out_rsp_id_i(out_rsp_id_i), .out_rsp_valid_i(out_rsp_valid_i),
    .out_rsp_ready_o(out_rsp_ready_o),
    .evt_hit_o(evt_hit_o), .evt_miss_o(evt_miss_o),
    .evt_prefetch_o(evt_prefetch_o), .evt_stall_o(evt_stall_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        exp_ready;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  id;
  } req_t;

  vec_t vecs [6];
  req_t exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // L1 memory model: each word is a scrambled copy of its own address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = word_of({a[31:4], 4'(w * 4)});
    return l;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [31:0] a, input logic [5:0] id);
    req_t r;
    r.addr = {a[31:4], 4'h0};
    r.id   = id;
    exp_q.push_back(r);
  endtask

  task automatic respond(input logic [5:0] id, input logic [31:0] a, input logic err);
    out_rsp_valid_i = 1'b1;
    out_rsp_id_i    = id;
    out_rsp_data_i  = line_of(a);
    out_rsp_error_i = err;
    tick();
    out_rsp_valid_i = 1'b0;
    out_rsp_error_i = 1'b0;
  endtask

  task automatic miss(input logic [31:0] a, input logic [5:0] id, input string name);
    in_valid_i = 1'b1;
    in_addr_i  = a;
    #1;
    check({name, "_ready"}, in_ready_o, 1'b0);
    check({name, "_evt_miss"}, evt_miss_o, 1'b1);
    push_req(a, id);
    tick();
    in_valid_i = 1'b0;
    check({name, "_req_valid"}, out_req_valid_o, 1'b1);
    tick();
  endtask

  task automatic hit(input logic [31:0] a, input logic err, input string name);
    in_valid_i = 1'b1;
    in_addr_i  = a;
    #1;
    check({name, "_ready"}, in_ready_o, 1'b1);
    check({name, "_data"}, in_data_o, word_of(a));
    check({name, "_err"}, in_error_o, err);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  // Request scoreboard: every accepted refill request must match the next expected one.
  always @(negedge clk) begin
    req_t e;
    if (rst_ni && out_req_valid_o && out_req_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_req: got addr %0h id %0h, expected no request",
                 out_req_addr_o, out_req_id_o);
      end else begin
        e = exp_q.pop_front();
        check("req_addr", out_req_addr_o, e.addr);
        check("req_id", out_req_id_o, e.id);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_1000, 1'b1, 1'b0, word_of(32'h0000_1000)};
    vecs[1] = '{32'h0000_1014, 1'b1, 1'b0, word_of(32'h0000_1014)};
    vecs[2] = '{32'h0000_1018, 1'b1, 1'b0, word_of(32'h0000_1018)};
    vecs[3] = '{32'h0000_1020, 1'b1, 1'b0, word_of(32'h0000_1020)};
    vecs[4] = '{32'h0000_102C, 1'b1, 1'b0, word_of(32'h0000_102C)};
    vecs[5] = '{32'h0000_100C, 1'b1, 1'b0, word_of(32'h0000_100C)};

    rst_ni = 1'b0; flush_valid_i = 1'b0; enable_prefetching_i = 1'b0;
    in_addr_i = '0; in_valid_i = 1'b0; out_req_ready_i = 1'b1;
    out_rsp_data_i = '0; out_rsp_error_i = 1'b0; out_rsp_id_i = '0; out_rsp_valid_i = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    check("reset_flags", {in_ready_o, in_error_o, out_req_valid_o, out_rsp_ready_o,
                          evt_hit_o, evt_miss_o, evt_prefetch_o, evt_stall_o}, 8'b0001_0000);
    check("reset_req", {out_req_addr_o, out_req_id_o, in_data_o}, 70'd0);

    // Cold miss: request in cycle 1, response in cycle 5, hit in cycle 6.
    in_valid_i = 1'b1; in_addr_i = 32'h0000_1000;
    #1;
    check("cold_evt_miss", evt_miss_o, 1'b1);
    check("cold_evt_stall", evt_stall_o, 1'b1);
    check("cold_ready_c0", in_ready_o, 1'b0);
    push_req(32'h0000_1000, 6'd0);
    tick();
    check("cold_req_valid_c1", out_req_valid_o, 1'b1);
    repeat (3) tick();
    tick();
    out_rsp_valid_i = 1'b1; out_rsp_id_i = 6'd0; out_rsp_data_i = line_of(32'h0000_1000);
    #1;
    check("cold_ready_c5", in_ready_o, 1'b0);
    tick();
    out_rsp_valid_i = 1'b0;
    #1;
    check("cold_ready_c6", in_ready_o, 1'b1);
    check("cold_data_c6", in_data_o, word_of(32'h0000_1000));
    check("cold_evt_hit", evt_hit_o, 1'b1);

    // Prefetch depth 2: 0x1010 then 0x1020, then a demand miss is withheld.
    enable_prefetching_i = 1'b1;
    #1;
    check("pf1_evt", evt_prefetch_o, 1'b1);
    push_req(32'h0000_1010, 6'd1);
    tick();
    check("pf_busy_evt", evt_prefetch_o, 1'b0);
    check("pf1_req_valid", out_req_valid_o, 1'b1);
    tick();
    check("pf2_evt", evt_prefetch_o, 1'b1);
    push_req(32'h0000_1020, 6'd2);
    tick();
    check("pf2_req_valid", out_req_valid_o, 1'b1);
    tick();
    check("pf_done_evt", evt_prefetch_o, 1'b0);
    in_addr_i = 32'h0000_2000;
    #1;
    check("maxpend_evt_miss", evt_miss_o, 1'b0);
    check("maxpend_evt_stall", evt_stall_o, 1'b1);
    tick();
    check("maxpend_no_req", out_req_valid_o, 1'b0);
    in_valid_i = 1'b0; enable_prefetching_i = 1'b0;

    // Out-of-order responses, then the hit vector table.
    respond(6'd2, 32'h0000_1020, 1'b0);
    respond(6'd1, 32'h0000_1010, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_valid_i = 1'b1; in_addr_i = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_ready", i), in_ready_o, vecs[i].exp_ready);
      check($sformatf("vec%0d_err", i), in_error_o, vecs[i].exp_err);
      check($sformatf("vec%0d_data", i), in_data_o, vecs[i].exp_data);
      tick();
    end
    in_valid_i = 1'b0;

    // Sticky refill error.
    miss(32'h0000_3000, 6'd3, "err_miss");
    respond(6'd3, 32'h0000_3000, 1'b1);
    hit(32'h0000_3008, 1'b1, "err_hit");

    // Flush in the cycle before the response: line stays INVALID, refetch re-requests.
    miss(32'h0000_4000, 6'd4, "fl_miss");
    flush_valid_i = 1'b1;
    tick();
    flush_valid_i = 1'b0;
    respond(6'd4, 32'h0000_4000, 1'b0);
    miss(32'h0000_4000, 6'd5, "fl_refetch");
    miss(32'h0000_1000, 6'd6, "fl_old_line");
    respond(6'd5, 32'h0000_4000, 1'b0);
    respond(6'd6, 32'h0000_1000, 1'b0);
    hit(32'h0000_4004, 1'b0, "fl_hit");

    // Round-robin: 9th miss evicts slot 0 (left pending); 17th skips pending slot 0.
    pulse_reset();
    for (int k = 0; k < 17; k++) begin
      miss(32'h0000_6000 + 32'(k * 16), (k == 16) ? 6'd1 : 6'(k % 8), $sformatf("rr%0d", k));
      if (k != 8 && k != 16) respond(6'(k % 8), 32'h0000_6000 + 32'(k * 16), 1'b0);
    end
    respond(6'd1, 32'h0000_6100, 1'b0);
    hit(32'h0000_6104, 1'b0, "rr_skip_hit");
    respond(6'd0, 32'h0000_6080, 1'b0);
    hit(32'h0000_6088, 1'b0, "rr_wrap_hit");

    // Reset mid-refill: the late response is dropped and the refetch misses again.
    miss(32'h0000_7000, 6'd2, "rst_miss");
    pulse_reset();
    respond(6'd2, 32'h0000_7000, 1'b0);
    miss(32'h0000_7000, 6'd0, "rst_refetch");
    respond(6'd0, 32'h0000_7000, 1'b0);
    hit(32'h0000_700C, 1'b0, "rst_hit");

    tick();
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
